// File: rtl/stepper_phase_driver.sv
// Converts step/dir pulses into four bipolar coil drives with half/full-step sequencing, position count and PWM hold.
// Latency: step first sampled high at edge k -> event after k+1, index/position at k+2, coil at k+3.
// No backpressure: every enabled step event is executed; events closer than MIN_STEP_CYCLES set a sticky fault.
module stepper_phase_driver #(
    parameter int unsigned IDLE_TIMEOUT_CYCLES = 5_000_000,
    parameter int unsigned HOLD_PWM_PERIOD     = 100,
    parameter int unsigned HOLD_PWM_DUTY       = 30,
    parameter int unsigned MIN_STEP_CYCLES     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    input  logic        dir,
    input  logic        enable,
    input  logic        half_step,
    input  logic        pos_clear,
    input  logic        fault_clear,
    output logic [3:0]  coil,
    output logic [31:0] position,
    output logic        idle,
    output logic        fault
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT_CYCLES + 1);
    localparam int PWM_W  = $clog2(HOLD_PWM_PERIOD);
    localparam int GAP_W  = (MIN_STEP_CYCLES < 1) ? 1 : $clog2(MIN_STEP_CYCLES + 1);

    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT_CYCLES);
    localparam logic [PWM_W-1:0]  PWM_LAST = PWM_W'(HOLD_PWM_PERIOD - 1);
    localparam logic [PWM_W:0]    PWM_DUTY = (PWM_W + 1)'(HOLD_PWM_DUTY);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(MIN_STEP_CYCLES);
    // Gap value loaded on an event: one cycle has elapsed by the time the counter is next read.
    localparam logic [GAP_W-1:0]  GAP_ONE  = (MIN_STEP_CYCLES >= 1) ? GAP_W'(1) : '0;

    logic              step_s1_q, step_s1_d;
    logic              step_s2_q, step_s2_d;
    logic              step_s2_dly_q, step_s2_dly_d;
    logic              dir_s1_q, dir_s1_d;
    logic              dir_s2_q, dir_s2_d;
    logic [2:0]        phase_q, phase_d;
    logic [31:0]       position_q, position_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              idle_q, idle_d;
    logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              fault_q, fault_d;
    logic [3:0]        coil_q, coil_d;

    logic              step_evt;
    logic              too_fast;
    logic              pwm_on;
    logic [2:0]        phase_inc;
    logic [3:0]        pattern;

    // Two-flop synchronisers for step and dir, plus the delayed step copy for edge detection
    always_comb begin
        step_s1_d     = step;
        step_s2_d     = step_s1_q;
        step_s2_dly_d = step_s2_q;
        dir_s1_d      = dir;
        dir_s2_d      = dir_s1_q;
        step_evt      = step_s2_q & ~step_s2_dly_q & enable;
    end

    // Phase index: half-step moves by one; full-step moves by two from odd states, by one from even to snap onto them
    always_comb begin
        phase_inc = (half_step || !phase_q[0]) ? 3'd1 : 3'd2;
        phase_d   = phase_q;
        if (step_evt) begin
            phase_d = dir_s2_q ? (phase_q + phase_inc) : (phase_q - phase_inc);
        end
    end

    // Signed position count, wrapping freely; clear overrides a coincident step
    always_comb begin
        position_d = position_q;
        if (pos_clear) begin
            position_d = '0;
        end else if (step_evt) begin
            position_d = dir_s2_q ? (position_q + 32'd1) : (position_q - 32'd1);
        end
    end

    // Idle timeout: saturating counter cleared by any event; idle follows the counter reaching the limit
    always_comb begin
        if (step_evt) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q;
        end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
        idle_d = (idle_cnt_d == IDLE_MAX);
    end

    // Free-running hold PWM counter
    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : (pwm_cnt_q + PWM_W'(1));
        pwm_on    = ({1'b0, pwm_cnt_q} < PWM_DUTY);
    end

    // Step spacing monitor: sticky fault, where a new violation beats a coincident clear
    always_comb begin
        too_fast = step_evt && (gap_q < GAP_MAX);
        if (step_evt) begin
            gap_d = GAP_ONE;
        end else if (gap_q < GAP_MAX) begin
            gap_d = gap_q + GAP_W'(1);
        end else begin
            gap_d = gap_q;
        end
        fault_d = fault_q;
        if (fault_clear) begin
            fault_d = 1'b0;
        end
        if (too_fast) begin
            fault_d = 1'b1;
        end
    end

    // Coil pattern lookup ({A+,A-,B+,B-}) and drive gating by enable and hold PWM
    always_comb begin
        case (phase_q)
            3'd0:    pattern = 4'b1000;
            3'd1:    pattern = 4'b1010;
            3'd2:    pattern = 4'b0010;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0100;
            3'd5:    pattern = 4'b0101;
            3'd6:    pattern = 4'b0001;
            default: pattern = 4'b1001;
        endcase
        if (!enable) begin
            coil_d = 4'b0000;
        end else if (idle_q) begin
            coil_d = pattern & {4{pwm_on}};
        end else begin
            coil_d = pattern;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            step_s1_q     <= 1'b0;
            step_s2_q     <= 1'b0;
            step_s2_dly_q <= 1'b0;
            dir_s1_q      <= 1'b0;
            dir_s2_q      <= 1'b0;
            phase_q       <= 3'd0;
            position_q    <= '0;
            idle_cnt_q    <= '0;
            idle_q        <= 1'b0;
            pwm_cnt_q     <= '0;
            gap_q         <= GAP_MAX;
            fault_q       <= 1'b0;
            coil_q        <= 4'b0000;
        end else begin
            step_s1_q     <= step_s1_d;
            step_s2_q     <= step_s2_d;
            step_s2_dly_q <= step_s2_dly_d;
            dir_s1_q      <= dir_s1_d;
            dir_s2_q      <= dir_s2_d;
            phase_q       <= phase_d;
            position_q    <= position_d;
            idle_cnt_q    <= idle_cnt_d;
            idle_q        <= idle_d;
            pwm_cnt_q     <= pwm_cnt_d;
            gap_q         <= gap_d;
            fault_q       <= fault_d;
            coil_q        <= coil_d;
        end
    end

    assign coil     = coil_q;
    assign position = position_q;
    assign idle     = idle_q;
    assign fault    = fault_q;

endmodule
